// File: rtl/wb_stage_ext.sv
// RV32I write-back stage: selects and formats the result, registers the
// register-file write port with stall/flush control, and counts retirements.
module wb_stage_ext #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   load_data,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [XLEN-1:0]   imm,
  input  logic [2:0]        load_funct3,
  input  logic [1:0]        addr_lsb,
  input  logic [REG_AW-1:0] rd,
  input  logic              regwrite_en,
  input  logic [1:0]        wb_sel,
  output logic [XLEN-1:0]   wd3,
  output logic [REG_AW-1:0] rd_a3,
  output logic              we3,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retire_count,
  output logic              cnt_wrap
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_IMM  = 2'b11
  } wb_sel_e;

  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] load_fmt;
  logic [XLEN-1:0] wb_data;

  // Half lane ignores addr_lsb[0]: misaligned halves are not trapped here.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    byte_lane = load_data[8*addr_lsb +: 8];
    half_lane = load_data[16*addr_lsb[1] +: 16];
    load_fmt  = load_data;
    case (load_funct3)
      3'b000:  load_fmt = XLEN'($signed(byte_lane));
      3'b100:  load_fmt = XLEN'(byte_lane);
      3'b001:  load_fmt = XLEN'($signed(half_lane));
      3'b101:  load_fmt = XLEN'(half_lane);
      3'b010:  load_fmt = XLEN'($signed(load_data[31:0]));
      default: load_fmt = load_data;
    endcase
  end

  always_comb begin
    wb_data = alu_out;
    case (wb_sel_e'(wb_sel))
      SEL_ALU:  wb_data = alu_out;
      SEL_LOAD: wb_data = load_fmt;
      SEL_PC4:  wb_data = pc_plus4;
      SEL_IMM:  wb_data = imm;
      default:  wb_data = alu_out;
    endcase
  end

  // Priority rst > flush > stall > capture; a stalled slot never commits.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      wd3          <= '0;
      rd_a3        <= '0;
      we3          <= 1'b0;
      wb_valid     <= 1'b0;
      retire_count <= '0;
      cnt_wrap     <= 1'b0;
    end else if (flush) begin
      wd3      <= '0;
      rd_a3    <= '0;
      we3      <= 1'b0;
      wb_valid <= 1'b0;
    end else if (stall) begin
      we3      <= 1'b0;
      wb_valid <= 1'b0;
    end else begin
      wd3      <= wb_data;
      rd_a3    <= rd;
      we3      <= in_valid && regwrite_en && (rd != '0);
      wb_valid <= in_valid;
      if (in_valid) begin
        retire_count <= retire_count + CNT_W'(1);
        if (&retire_count) cnt_wrap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_ext.sv
// Scoreboard bench for wb_stage_ext: the driver pushes expected register
// state per cycle; a monitor pops and compares one cycle later.
module tb_wb_stage_ext;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [XLEN-1:0]   alu_out = '0, load_data = '0, pc_plus4 = '0, imm = '0;
  logic [2:0]        load_funct3 = '0;
  logic [1:0]        addr_lsb = '0;
  logic [REG_AW-1:0] rd = '0;
  logic              regwrite_en = 1'b0;
  logic [1:0]        wb_sel = '0;
  logic [XLEN-1:0]   wd3;
  logic [REG_AW-1:0] rd_a3;
  logic              we3, wb_valid;
  logic [CNT_W-1:0]  retire_count;
  logic              cnt_wrap;

  wb_stage_ext #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_out(alu_out), .load_data(load_data), .pc_plus4(pc_plus4), .imm(imm),
    .load_funct3(load_funct3), .addr_lsb(addr_lsb), .rd(rd),
    .regwrite_en(regwrite_en), .wb_sel(wb_sel), .wd3(wd3), .rd_a3(rd_a3),
    .we3(we3), .wb_valid(wb_valid), .retire_count(retire_count), .cnt_wrap(cnt_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, in_valid, stall, flush, regwrite_en;
    bit [31:0] alu_out, load_data, pc_plus4, imm;
    bit [2:0] funct3;
    bit [1:0] addr_lsb, wb_sel;
    bit [4:0] rd;
  } stim_t;

  typedef struct {
    bit [31:0] wd3;
    bit [4:0]  rd_a3;
    bit        we3, wb_valid, wrap;
    int        count;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 0;

  // Reference model state
  bit [31:0] m_wd3;
  bit [4:0]  m_rd;
  int        m_count;
  bit        m_wrap;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Load result from the RISC-V rules with plain arithmetic.
  function automatic bit [31:0] ref_load(bit [31:0] d, bit [2:0] f3, bit [1:0] lsb);
    longint b = (d >> (8 * lsb)) & 255;
    longint h = (d >> (16 * (lsb / 2))) & 65535;
    case (f3)
      3'd0: return 32'(b - ((b >= 128) ? 256 : 0));
      3'd4: return 32'(b);
      3'd1: return 32'(h - ((h >= 32768) ? 65536 : 0));
      3'd5: return 32'(h);
      default: return d;
    endcase
  endfunction

  function automatic bit [31:0] ref_data(stim_t s);
    case (s.wb_sel)
      2'd0: return s.alu_out;
      2'd1: return ref_load(s.load_data, s.funct3, s.addr_lsb);
      2'd2: return s.pc_plus4;
      default: return s.imm;
    endcase
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst = s.rst; in_valid = s.in_valid; stall = s.stall; flush = s.flush;
    alu_out = s.alu_out; load_data = s.load_data; pc_plus4 = s.pc_plus4; imm = s.imm;
    load_funct3 = s.funct3; addr_lsb = s.addr_lsb; rd = s.rd;
    regwrite_en = s.regwrite_en; wb_sel = s.wb_sel;
    e.we3 = 0; e.wb_valid = 0;
    if (s.rst) begin
      m_wd3 = 0; m_rd = 0; m_count = 0; m_wrap = 0;
    end else if (s.flush) begin
      m_wd3 = 0; m_rd = 0;
    end else if (!s.stall) begin
      m_wd3 = ref_data(s);
      m_rd  = s.rd;
      if (s.in_valid) begin
        e.wb_valid = 1;
        e.we3 = s.regwrite_en && (s.rd != 0);
        m_count = m_count + 1;
        if (m_count == CNT_MOD) begin
          m_count = 0;
          m_wrap = 1;
        end
      end
    end
    e.wd3 = m_wd3; e.rd_a3 = m_rd; e.count = m_count; e.wrap = m_wrap;
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t cap(bit [1:0] sel, bit [31:0] val, bit [4:0] r);
    stim_t s;
    s = idle();
    s.in_valid = 1; s.regwrite_en = 1; s.wb_sel = sel; s.rd = r;
    s.alu_out = val; s.load_data = val; s.pc_plus4 = val; s.imm = val;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(0, 63) == 0);
    s.in_valid = ($urandom_range(0, 3) != 0);
    s.stall = ($urandom_range(0, 4) == 0);
    s.flush = ($urandom_range(0, 6) == 0);
    s.regwrite_en = $urandom_range(0, 1);
    s.alu_out = $urandom; s.load_data = $urandom; s.pc_plus4 = $urandom; s.imm = $urandom;
    s.funct3 = 3'($urandom_range(0, 7));
    s.addr_lsb = 2'($urandom_range(0, 3));
    s.wb_sel = 2'($urandom_range(0, 3));
    s.rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    return s;
  endfunction

  // Monitor: compare registered outputs just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wd3", wd3, e.wd3);
        check("rd_a3", rd_a3, e.rd_a3);
        check("we3", we3, e.we3);
        check("wb_valid", wb_valid, e.wb_valid);
        check("retire_count", retire_count, e.count);
        check("cnt_wrap", cnt_wrap, e.wrap);
      end
    end
  end

  initial begin
    stim_t s;
    bit [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    bit [1:0]  lsbs[5] = '{2'd2, 2'd3, 2'd0, 2'd3, 2'd0};

    // Reset with stall and flush asserted, then an ALU capture.
    s = idle(); s.rst = 1; s.stall = 1; s.flush = 1;
    drive(s);
    drive(cap(2'd0, 32'h0000_1234, 5'd5));

    // Load formatting across lanes and types.
    for (int i = 0; i < 5; i++) begin
      s = cap(2'd1, 32'h0000_0000, 5'd7);
      s.load_data = 32'h80FF_7F01; s.funct3 = f3s[i]; s.addr_lsb = lsbs[i];
      drive(s);
    end
    for (int f = 3; f <= 7; f++) begin
      if (f == 4 || f == 5) continue;
      s = cap(2'd1, 32'hC3A5_5A3C, 5'd8); s.funct3 = 3'(f);
      drive(s);
    end

    // Write to x0 retires but does not write.
    drive(cap(2'd2, 32'h0000_0104, 5'd0));
    drive(cap(2'd3, 32'hABCD_E000, 5'd9));

    // Capture, hold stall for three cycles, then release.
    drive(cap(2'd0, 32'hDEAD_BEEF, 5'd12));
    for (int i = 0; i < 3; i++) begin
      s = cap(2'd0, 32'h1111_2222, 5'd13); s.stall = 1;
      drive(s);
    end
    drive(cap(2'd0, 32'h1111_2222, 5'd13));

    // Flush with stall on a valid instruction.
    s = cap(2'd0, 32'h5555_AAAA, 5'd14); s.stall = 1; s.flush = 1;
    drive(s);

    // Idle slot: data loaded, nothing retires.
    s = cap(2'd3, 32'h0BAD_F00D, 5'd3); s.in_valid = 0;
    drive(s);

    // Counter wrap: 16 captures, one more, then reset.
    for (int i = 0; i < CNT_MOD + 1; i++) drive(cap(2'd0, 32'(i), 5'(i + 1)));
    s = idle(); s.rst = 1;
    drive(s);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) drive(rnd());
    drive(idle());

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
